sp_sequencer: RTL and testbench

- Initiator side of the SP extraction interface. On each window-ready `start`, walks every (channel, SPI index) pair in order and issues one-cycle requests to the SP extractor.
- Waits for the extractor's `done`, captures the returned SPV, and streams each result downstream on a valid/ready port with index tags and a last flag.
- Sits between the window buffer/control FSM and the HV encoder, which consumes SPVs to select item-memory vectors.

---
 rtl/sp_pkg.sv | 30 +++
 rtl/sp_index_counter.sv | 45 ++++
 rtl/sp_sequencer.sv | 154 +++++++++++++++
 tb/tb_sp_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared definitions for the SP extraction sequencer: default dimensions,
// derived index widths, the sequencer state encoding and the result record
// handed to the HV encoder.
package sp_pkg;

  localparam int NUM_CHS        = 17;
  localparam int NUM_SPI        = 6;
  localparam int NUM_SPV        = 64;
  localparam int TIMEOUT_CYCLES = 15;

  localparam int CH_W  = $clog2(NUM_CHS);
  localparam int SPI_W = $clog2(NUM_SPI);
  localparam int SPV_W = $clog2(NUM_SPV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // One extracted result as seen by the downstream consumer.
  typedef struct packed {
    logic [CH_W-1:0]  c;
    logic [SPI_W-1:0] spi;
    logic [SPV_W-1:0] spv;
    logic             last;
  } sp_result_t;

endpackage

// File: rtl/sp_index_counter.sv
// Nested (channel, SPI index) counter. SPI is the inner index; the channel
// advances when SPI wraps and saturates at its last value.
module sp_index_counter #(
  parameter int NUM_CHS = 17,
  parameter int NUM_SPI = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       advance,
  output logic [$clog2(NUM_CHS)-1:0] c,
  output logic [$clog2(NUM_SPI)-1:0] spi,
  output logic                       is_last
);

  localparam int CW = $clog2(NUM_CHS);
  localparam int SW = $clog2(NUM_SPI);
  localparam logic [CW-1:0] C_MAX   = CW'(NUM_CHS - 1);
  localparam logic [SW-1:0] SPI_MAX = SW'(NUM_SPI - 1);

  logic [CW-1:0] c_reg;
  logic [SW-1:0] spi_reg;

  // Clear to (0,0) or step to the next pair in channel-major order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      c_reg   <= '0;
      spi_reg <= '0;
    end else if (advance) begin
      if (spi_reg == SPI_MAX) begin
        spi_reg <= '0;
        if (c_reg != C_MAX) begin
          c_reg <= c_reg + CW'(1);
        end
      end else begin
        spi_reg <= spi_reg + SW'(1);
      end
    end
  end

  assign c       = c_reg;
  assign spi     = spi_reg;
  assign is_last = (c_reg == C_MAX) && (spi_reg == SPI_MAX);

endmodule

// File: rtl/sp_sequencer.sv
// Initiator for the SP extractor: on start, walks every (channel, SPI) pair,
// issues a one-cycle request, waits for the registered done, and presents
// each SPV downstream on a valid/ready port. A missing done aborts the frame
// and raises a sticky error until the next accepted start.
module sp_sequencer #(
  parameter int NUM_CHS        = sp_pkg::NUM_CHS,
  parameter int NUM_SPI        = sp_pkg::NUM_SPI,
  parameter int NUM_SPV        = sp_pkg::NUM_SPV,
  parameter int TIMEOUT_CYCLES = sp_pkg::TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       ext_en,
  output logic [$clog2(NUM_CHS)-1:0] ext_c,
  output logic [$clog2(NUM_SPI)-1:0] ext_spi,
  input  logic                       ext_done,
  input  logic [$clog2(NUM_SPV)-1:0] ext_spv,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_CHS)-1:0] out_c,
  output logic [$clog2(NUM_SPI)-1:0] out_spi,
  output logic [$clog2(NUM_SPV)-1:0] out_spv,
  output logic                       out_last,
  output logic                       err
);

  import sp_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_e state_reg, state_next;
  logic   idx_clear, idx_advance, idx_last;
  logic   timed_out;

  logic [TO_W-1:0]            to_cnt_reg;
  logic                       err_reg;
  logic                       out_valid_reg;
  logic [$clog2(NUM_CHS)-1:0] out_c_reg;
  logic [$clog2(NUM_SPI)-1:0] out_spi_reg;
  logic [$clog2(NUM_SPV)-1:0] out_spv_reg;
  logic                       out_last_reg;

  // The counter value doubles as the request address: it only moves when
  // entering ISSUE, so it holds its last value everywhere else.
  sp_index_counter #(
    .NUM_CHS (NUM_CHS),
    .NUM_SPI (NUM_SPI)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .advance (idx_advance),
    .c       (ext_c),
    .spi     (ext_spi),
    .is_last (idx_last)
  );

  assign timed_out = (state_reg == ST_WAIT) && !ext_done && (to_cnt_reg == TO_MAX);

  // Next-state decode plus the counter clear/advance strobes.
  always_comb begin
    state_next  = state_reg;
    idx_clear   = 1'b0;
    idx_advance = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          idx_clear  = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (ext_done) begin
          state_next = ST_OUT;
        end else if (timed_out) begin
          state_next = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_valid_reg && out_ready) begin
          if (out_last_reg) begin
            state_next = ST_IDLE;
          end else begin
            idx_advance = 1'b1;
            state_next  = ST_ISSUE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counts WAIT cycles without done; restarted by every request.
  always_ff @(posedge clk) begin
    if (rst || state_reg == ST_ISSUE) begin
      to_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT && !ext_done && !timed_out) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  // Sticky timeout flag, cleared only when a new frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && start) begin
      err_reg <= 1'b0;
    end else if (timed_out) begin
      err_reg <= 1'b1;
    end
  end

  // Capture the extractor result and hold it until the downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_c_reg     <= '0;
      out_spi_reg   <= '0;
      out_spv_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else if (state_reg == ST_WAIT && ext_done) begin
      out_valid_reg <= 1'b1;
      out_c_reg     <= ext_c;
      out_spi_reg   <= ext_spi;
      out_spv_reg   <= ext_spv;
      out_last_reg  <= idx_last;
    end else if (state_reg == ST_OUT && out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign ext_en    = (state_reg == ST_ISSUE);
  assign out_valid = out_valid_reg;
  assign out_c     = out_c_reg;
  assign out_spi   = out_spi_reg;
  assign out_spv   = out_spv_reg;
  assign out_last  = out_last_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sp_sequencer.sv
// Self-checking bench for sp_sequencer with a registered extractor model
// and a negedge monitor that logs handshakes and request strobes.
module tb_sp_sequencer;

  localparam int NCH = 17;
  localparam int NSP = 6;
  localparam int NPAIR = NCH * NSP;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       ext_en;
  logic [4:0] ext_c;
  logic [2:0] ext_spi;
  logic       ext_done = 1'b0;
  logic [5:0] ext_spv = 6'd0;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_c;
  logic [2:0] out_spi;
  logic [5:0] out_spv;
  logic       out_last;
  logic       err;

  sp_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .ext_en    (ext_en),
    .ext_c     (ext_c),
    .ext_spi   (ext_spi),
    .ext_done  (ext_done),
    .ext_spv   (ext_spv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_spi   (out_spi),
    .out_spv   (out_spv),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Extractor lookup table and model state.
  logic [5:0] tbl [NPAIR];
  bit         mute = 1'b0;

  // Registered extractor: done is high the cycle after en is sampled.
  always @(posedge clk) begin
    ext_done <= 1'b0;
    if (ext_en && !mute) begin
      ext_done <= 1'b1;
      ext_spv  <= tbl[int'(ext_c) * NSP + int'(ext_spi)];
    end
  end

  // Monitor logs.
  int   n_res, en_cnt, en_dbl, cap_cnt, valid_seen, first_en, busy_fall, start_cyc;
  bit   en_prev, busy_prev, valid_prev;
  logic [4:0] r_c   [128];
  logic [2:0] r_spi [128];
  logic [5:0] r_spv [128];
  logic       r_last[128];
  int         r_cyc [128];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (n_res < 128) begin
        r_c[n_res]    = out_c;
        r_spi[n_res]  = out_spi;
        r_spv[n_res]  = out_spv;
        r_last[n_res] = out_last;
        r_cyc[n_res]  = cyc - start_cyc;
      end
      n_res++;
    end
    if (out_valid) valid_seen++;
    if (out_valid && !valid_prev) cap_cnt++;
    valid_prev = out_valid;
    if (ext_en) begin
      if (en_cnt == 0) first_en = cyc - start_cyc;
      en_cnt++;
      if (en_prev) en_dbl++;
    end
    en_prev = ext_en;
    if (busy_prev && !busy) busy_fall = cyc - start_cyc;
    busy_prev = busy;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    n_res = 0; en_cnt = 0; en_dbl = 0; cap_cnt = 0; valid_seen = 0;
    first_en = -1; busy_fall = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    chk(name, {busy, ext_en, ext_c, ext_spi, out_valid, out_c, out_spi,
               out_spv, out_last, err}, 27'd0);
  endtask

  typedef struct {
    int   idx;
    int   c;
    int   spi;
    int   spv;
    logic last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    int en_before;
    bit hit;

    for (int i = 0; i < NPAIR; i++) tbl[i] = 6'((i * 7 + 3) % 64);
    tbl[0] = 6'd0;  tbl[1] = 6'd1;  tbl[2] = 6'd1;  tbl[3] = 6'd2;
    tbl[79] = 6'd16; tbl[81] = 6'd15; tbl[101] = 6'd42;

    vecs[0] = '{0,   0,  0, 0,  1'b0};
    vecs[1] = '{1,   0,  1, 1,  1'b0};
    vecs[2] = '{3,   0,  3, 2,  1'b0};
    vecs[3] = '{79,  13, 1, 16, 1'b0};
    vecs[4] = '{81,  13, 3, 15, 1'b0};
    vecs[5] = '{101, 16, 5, 42, 1'b1};

    rst = 1'b1; start = 1'b0; out_ready = 1'b1; start_cyc = 0;
    clear_logs();
    en_prev = 0; busy_prev = 0; valid_prev = 0;
    do_reset();
    check_all_zero("reset_outputs");

    // Full frame, out_ready held high.
    clear_logs();
    pulse_start();
    wait_idle("frame1_idle", 400);
    repeat (2) @(negedge clk);
    chk("frame1_count", n_res, NPAIR);
    for (int v = 0; v < 6; v++) begin
      int k;
      k = vecs[v].idx;
      chk($sformatf("vec%0d_c", k),    r_c[k],    vecs[v].c);
      chk($sformatf("vec%0d_spi", k),  r_spi[k],  vecs[v].spi);
      chk($sformatf("vec%0d_spv", k),  r_spv[k],  vecs[v].spv);
      chk($sformatf("vec%0d_last", k), r_last[k], vecs[v].last);
    end
    for (int k = 0; k < NPAIR; k++) begin
      chk($sformatf("order%0d", k), {r_c[k], r_spi[k], r_spv[k], r_last[k]},
          {5'(k / NSP), 3'(k % NSP), tbl[k], (k == NPAIR - 1) ? 1'b1 : 1'b0});
    end
    chk("first_en_latency", first_en, 1);
    chk("last_handshake_cycle", r_cyc[NPAIR - 1], 306);
    chk("busy_fall_cycle", busy_fall, 307);
    chk("en_count", en_cnt, NPAIR);
    chk("en_back_to_back", en_dbl, 0);
    chk("capture_per_en", cap_cnt, en_cnt);
    chk("frame1_err", err, 0);

    // Backpressure at pair (0,2).
    clear_logs();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid && out_c == 5'd0 && out_spi == 3'd1;
    end
    chk("bp_reach_01", hit, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid;
    end
    chk("bp_reach_02", hit, 1);
    en_before = en_cnt;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (!out_valid || out_spv != 6'd1 || out_spi != 3'd2 || out_c != 5'd0 || ext_en) bad++;
    end
    chk("bp_held_stable", bad, 0);
    chk("bp_no_ext_en", en_cnt, en_before);
    @(posedge clk); #1;
    out_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = ext_en;
    end
    chk("bp_next_en", hit, 1);
    chk("bp_next_c", ext_c, 0);
    chk("bp_next_spi", ext_spi, 3);
    wait_idle("bp_idle", 400);
    chk("bp_count", n_res, NPAIR);

    // Timeout: extractor never answers.
    mute = 1'b1;
    clear_logs();
    pulse_start();
    repeat (25) @(negedge clk);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_busy_fall_cycle", busy_fall, 17);
    chk("to_no_valid", valid_seen, 0);
    mute = 1'b0;
    clear_logs();
    pulse_start();
    @(negedge clk);
    chk("to_err_cleared", err, 0);
    chk("to_restart_busy", busy, 1);
    wait_idle("to_restart_idle", 400);
    chk("to_restart_count", n_res, NPAIR);

    // start pulses while busy are ignored.
    clear_logs();
    pulse_start();
    while (cyc - start_cyc < 10) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc - start_cyc < 50) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busy_start_idle", 400);
    repeat (3) @(negedge clk);
    chk("busy_start_count", n_res, NPAIR);
    chk("busy_start_last_cycle", r_cyc[NPAIR - 1], 306);
    chk("busy_start_still_idle", busy, 0);

    // Reset during OUT at pair (5,2).
    clear_logs();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid && out_c == 5'd5 && out_spi == 3'd1;
    end
    chk("rst_reach_51", hit, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid;
    end
    chk("rst_at_52", {out_c, out_spi}, {5'd5, 3'd2});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check_all_zero("rst_mid_outputs");
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", busy, 0);
    clear_logs();
    pulse_start();
    wait_idle("rst_restart_idle", 400);
    chk("rst_restart_first", {r_c[0], r_spi[0]}, 8'd0);
    chk("rst_restart_count", n_res, NPAIR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
